// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between instruction fetch
// (imem side) and the data memory unit (dmem side).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_addr/_addr_valid       fetch request (held until imem_data_valid)
//   imem_data/_data_valid/_err  fetch response (one-cycle pulse, err = timeout)
//   dmem_addr/_addr_valid       data request (held until dmem_data_valid)
//   dmem_we, dmem_wdata         data write enable and write data
//   dmem_data/_data_valid/_err  data response (one-cycle pulse, err = timeout)
//   bus_addr/_addr_valid        external request
//   bus_we, bus_wdata           external write enable and write data
//   bus_data/_data_valid        external single-cycle response
//
// State  | meaning
// IDLE   | sample requests, grant dmem first unless imem has starved
// BUSY_I | fetch transfer on the bus, waiting for response or timeout
// BUSY_D | data transfer on the bus, waiting for response or timeout
// RESP_I | imem_data_valid pulse, back to IDLE next
// RESP_D | dmem_data_valid pulse, back to IDLE next
//
// All outputs are registered.

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [63:0] imem_addr,
  input  logic        imem_addr_valid,
  output logic [63:0] imem_data,
  output logic        imem_data_valid,
  output logic        imem_err,

  input  logic [63:0] dmem_addr,
  input  logic        dmem_addr_valid,
  input  logic        dmem_we,
  input  logic [63:0] dmem_wdata,
  output logic [63:0] dmem_data,
  output logic        dmem_data_valid,
  output logic        dmem_err,

  output logic [63:0] bus_addr,
  output logic        bus_addr_valid,
  output logic        bus_we,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_data,
  input  logic        bus_data_valid
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [63:0] bus_addr_q, bus_addr_d;
  logic        bus_addr_valid_q, bus_addr_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;

  logic [63:0] imem_data_q, imem_data_d;
  logic        imem_data_valid_q, imem_data_valid_d;
  logic        imem_err_q, imem_err_d;

  logic [63:0] dmem_data_q, dmem_data_d;
  logic        dmem_data_valid_q, dmem_data_valid_d;
  logic        dmem_err_q, dmem_err_d;

  logic        grant_d;
  logic        xfer_done;

  // dmem wins unless both request and imem has been passed over STARVE_LIMIT times.
  assign grant_d   = dmem_addr_valid && (!imem_addr_valid || (starve_q != STARVE_MAX));
  // A bus response in the timeout cycle still counts as a real response.
  assign xfer_done = bus_data_valid || (to_cnt_q == TO_LAST);

  always_comb begin
    state_d           = state_q;
    starve_d          = starve_q;
    to_cnt_d          = to_cnt_q;
    bus_addr_d        = bus_addr_q;
    bus_addr_valid_d  = bus_addr_valid_q;
    bus_we_d          = bus_we_q;
    bus_wdata_d       = bus_wdata_q;
    imem_data_d       = imem_data_q;
    imem_data_valid_d = 1'b0;
    imem_err_d        = imem_err_q;
    dmem_data_d       = dmem_data_q;
    dmem_data_valid_d = 1'b0;
    dmem_err_d        = dmem_err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d          = S_BUSY_D;
          bus_addr_d       = dmem_addr;
          bus_we_d         = dmem_we;
          bus_wdata_d      = dmem_wdata;
          bus_addr_valid_d = 1'b1;
          to_cnt_d         = '0;
          if (imem_addr_valid) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (imem_addr_valid) begin
          state_d          = S_BUSY_I;
          bus_addr_d       = imem_addr;
          bus_we_d         = 1'b0;
          bus_wdata_d      = '0;
          bus_addr_valid_d = 1'b1;
          to_cnt_d         = '0;
          starve_d         = '0;
        end
      end

      S_BUSY_I, S_BUSY_D: begin
        if (xfer_done) begin
          bus_addr_valid_d = 1'b0;
          if (state_q == S_BUSY_D) begin
            state_d           = S_RESP_D;
            dmem_data_valid_d = 1'b1;
            dmem_err_d        = !bus_data_valid;
            if (!bus_data_valid) begin
              dmem_data_d = '0;
            end else if (!bus_we_q) begin
              dmem_data_d = bus_data;
            end
          end else begin
            state_d           = S_RESP_I;
            imem_data_valid_d = 1'b1;
            imem_err_d        = !bus_data_valid;
            imem_data_d       = bus_data_valid ? bus_data : '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_RESP_I, S_RESP_D: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      starve_q          <= '0;
      to_cnt_q          <= '0;
      bus_addr_q        <= '0;
      bus_addr_valid_q  <= 1'b0;
      bus_we_q          <= 1'b0;
      bus_wdata_q       <= '0;
      imem_data_q       <= '0;
      imem_data_valid_q <= 1'b0;
      imem_err_q        <= 1'b0;
      dmem_data_q       <= '0;
      dmem_data_valid_q <= 1'b0;
      dmem_err_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      starve_q          <= starve_d;
      to_cnt_q          <= to_cnt_d;
      bus_addr_q        <= bus_addr_d;
      bus_addr_valid_q  <= bus_addr_valid_d;
      bus_we_q          <= bus_we_d;
      bus_wdata_q       <= bus_wdata_d;
      imem_data_q       <= imem_data_d;
      imem_data_valid_q <= imem_data_valid_d;
      imem_err_q        <= imem_err_d;
      dmem_data_q       <= dmem_data_d;
      dmem_data_valid_q <= dmem_data_valid_d;
      dmem_err_q        <= dmem_err_d;
    end
  end

  assign bus_addr        = bus_addr_q;
  assign bus_addr_valid  = bus_addr_valid_q;
  assign bus_we          = bus_we_q;
  assign bus_wdata       = bus_wdata_q;
  assign imem_data       = imem_data_q;
  assign imem_data_valid = imem_data_valid_q;
  assign imem_err        = imem_err_q;
  assign dmem_data       = dmem_data_q;
  assign dmem_data_valid = dmem_data_valid_q;
  assign dmem_err        = dmem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A transaction-level model decides grants and
// response timing from the arbitration rules, pushes expected bus activity and
// responses into queues, and a negedge monitor compares the DUT against them.

module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic [63:0] imem_data;
  logic        imem_data_valid;
  logic        imem_err;
  logic [63:0] dmem_addr;
  logic        dmem_addr_valid;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_data;
  logic        dmem_data_valid;
  logic        dmem_err;
  logic [63:0] bus_addr;
  logic        bus_addr_valid;
  logic        bus_we;
  logic [63:0] bus_wdata;
  logic [63:0] bus_data;
  logic        bus_data_valid;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid), .imem_err(imem_err),
    .dmem_addr(dmem_addr), .dmem_addr_valid(dmem_addr_valid),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_data(dmem_data), .dmem_data_valid(dmem_data_valid), .dmem_err(dmem_err),
    .bus_addr(bus_addr), .bus_addr_valid(bus_addr_valid),
    .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_data(bus_data), .bus_data_valid(bus_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    int          stop;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } grant_t;

  typedef struct {
    int          cyc;
    int          side;   // 0 = imem, 1 = dmem
    logic [63:0] data;
    logic        err;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;
  bit mon_en = 0;

  // requester model, index 0 = imem, 1 = dmem
  bit          req [2];
  logic [63:0] raddr [2];
  logic        rwe [2];
  logic [63:0] rwd [2];
  int          drop_at [2];
  bit          reissue [2];

  // arbitration / bus model
  int          next_free;
  int          starve;
  logic [63:0] last_d;
  int          xs, xe, bus_resp_cyc;
  logic [63:0] bus_resp_data;

  // stimulus knobs
  int          p_req  = 0;
  int          p_junk = 0;
  int          lat_fix = 1;
  bit          silent = 0;
  bit          fix_en = 0;
  logic [63:0] fix_data = '0;

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s @cyc %0d: got %b, want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic apply_inputs();
    imem_addr_valid = req[0];
    imem_addr       = raddr[0];
    dmem_addr_valid = req[1];
    dmem_addr       = raddr[1];
    dmem_we         = rwe[1];
    dmem_wdata      = rwd[1];
  endtask

  task automatic queue_req(input int s, input logic [63:0] a, input logic w, input logic [63:0] wd);
    req[s]   = 1'b1;
    raddr[s] = a;
    rwe[s]   = (s == 1) ? w : 1'b0;
    rwd[s]   = (s == 1) ? wd : 64'd0;
    apply_inputs();
  endtask

  task automatic new_req(input int s);
    queue_req(s, {$urandom, $urandom}, 1'($urandom_range(1)), {$urandom, $urandom});
  endtask

  // Decide the winner of the current sample cycle and schedule the whole transfer.
  task automatic grant();
    int          who, len;
    logic [63:0] d, e;
    grant_t      g;
    resp_t       r;
    if (req[0] && req[1]) who = (starve == STARVE_LIMIT) ? 0 : 1;
    else                  who = req[1] ? 1 : 0;
    if (who == 1 && req[0]) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
    else                    starve = 0;
    len = silent ? TIMEOUT : ((lat_fix != 0) ? lat_fix : int'($urandom_range(5, 1)));
    d   = fix_en ? fix_data : {$urandom, $urandom};
    g.start = cyc + 1;
    g.stop  = cyc + len;
    g.addr  = raddr[who];
    g.we    = (who == 1) ? rwe[1] : 1'b0;
    g.wdata = (who == 1) ? rwd[1] : 64'd0;
    gq.push_back(g);
    xs = cyc + 1;
    xe = cyc + len;
    bus_resp_cyc  = silent ? -1 : cyc + len;
    bus_resp_data = d;
    if (silent)                e = 64'd0;
    else if (who == 1 && g.we) e = last_d;
    else                       e = d;
    if (who == 1) last_d = e;
    r.cyc  = cyc + len + 1;
    r.side = who;
    r.data = e;
    r.err  = silent;
    rq.push_back(r);
    next_free    = cyc + len + 2;
    drop_at[who] = cyc + len + 2;
  endtask

  task automatic step();
    if (cyc >= next_free && (req[0] || req[1])) grant();
    @(posedge clk);
    #1;
    cyc++;
    if (bus_resp_cyc == cyc) begin
      bus_data_valid = 1'b1;
      bus_data       = bus_resp_data;
    end else if (!(cyc >= xs && cyc <= xe) && int'($urandom_range(99)) < p_junk) begin
      bus_data_valid = 1'b1;
      bus_data       = {$urandom, $urandom};
    end else begin
      bus_data_valid = 1'b0;
      bus_data       = {$urandom, $urandom};
    end
    for (int s = 0; s < 2; s++) begin
      if (req[s] && cyc == drop_at[s]) begin
        req[s] = 1'b0;
        if (reissue[s]) new_req(s);
      end
      if (!req[s] && int'($urandom_range(99)) < p_req) new_req(s);
    end
    apply_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req[0] || req[1] || cyc <= next_free) && n < 600) begin
      step();
      n++;
    end
    chk1("drain_within_bound", (n < 600), 1'b1);
  endtask

  task automatic do_reset(input bit late);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk1 ("rst_bus_addr_valid", bus_addr_valid, 1'b0);
    chk64("rst_bus_addr", bus_addr, 64'd0);
    chk1 ("rst_bus_we", bus_we, 1'b0);
    chk64("rst_bus_wdata", bus_wdata, 64'd0);
    chk64("rst_imem_data", imem_data, 64'd0);
    chk1 ("rst_imem_valid_err", imem_data_valid | imem_err, 1'b0);
    chk64("rst_dmem_data", dmem_data, 64'd0);
    chk1 ("rst_dmem_valid_err", dmem_data_valid | dmem_err, 1'b0);
    gq.delete();
    rq.delete();
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; raddr[s] = '0; rwe[s] = 1'b0; rwd[s] = '0;
      drop_at[s] = -1; reissue[s] = 1'b0;
    end
    starve = 0; last_d = '0;
    xs = -1; xe = -1; bus_resp_cyc = -1; bus_resp_data = '0;
    apply_inputs();
    bus_data_valid = 1'b0;
    bus_data       = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc++;
    rst_n     = 1'b1;
    next_free = cyc;
    if (late) begin
      bus_data_valid = 1'b1;
      bus_data       = 64'hBAD0_0000_CAFE_F00D;
    end
    mon_en = 1;
  endtask

  resp_t mr;
  grant_t mg;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gq.size() > 0 && cyc >= gq[0].start) begin
        chk1 ("bus_addr_valid", bus_addr_valid, 1'b1);
        chk64("bus_addr", bus_addr, gq[0].addr);
        chk1 ("bus_we", bus_we, gq[0].we);
        chk64("bus_wdata", bus_wdata, gq[0].wdata);
        if (cyc >= gq[0].stop) mg = gq.pop_front();
      end else begin
        chk1("bus_addr_valid_idle", bus_addr_valid, 1'b0);
      end
      if (rq.size() > 0 && cyc == rq[0].cyc) begin
        mr = rq.pop_front();
        chk1("imem_data_valid", imem_data_valid, mr.side == 0);
        chk1("dmem_data_valid", dmem_data_valid, mr.side == 1);
        if (mr.side == 0) begin
          chk64("imem_data", imem_data, mr.data);
          chk1 ("imem_err", imem_err, mr.err);
        end else begin
          chk64("dmem_data", dmem_data, mr.data);
          chk1 ("dmem_err", dmem_err, mr.err);
        end
      end else begin
        chk1("imem_data_valid_idle", imem_data_valid, 1'b0);
        chk1("dmem_data_valid_idle", dmem_data_valid, 1'b0);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    imem_addr = '0; imem_addr_valid = 1'b0;
    dmem_addr = '0; dmem_addr_valid = 1'b0; dmem_we = 1'b0; dmem_wdata = '0;
    bus_data = '0;  bus_data_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // single fetch, bus answers one cycle after the request appears
    lat_fix = 1; fix_en = 1; fix_data = 64'h0000_0000_DEAD_BEEF;
    queue_req(0, 64'h1000, 1'b0, 64'd0);
    drain();
    fix_en = 0;

    // simultaneous requests: dmem first, then imem
    queue_req(0, 64'h1_0000, 1'b0, 64'd0);
    queue_req(1, 64'h2000, 1'b0, 64'd0);
    drain();

    // starvation: imem held while dmem re-requests every sample cycle
    reissue[1] = 1'b1;
    queue_req(0, 64'h1_4000, 1'b0, 64'd0);
    queue_req(1, 64'h2100, 1'b0, 64'd0);
    run(20);
    reissue[1] = 1'b0;
    drain();

    // dmem write: bus_we/wdata held, dmem_data keeps the last read value
    lat_fix = 3;
    queue_req(1, 64'h3000, 1'b1, 64'h55);
    drain();

    // silent bus: timeout error with zero data
    silent = 1;
    queue_req(1, 64'h5000, 1'b0, 64'd0);
    drain();
    silent = 0;

    // response arriving exactly on the timeout cycle wins
    lat_fix = TIMEOUT; fix_en = 1; fix_data = 64'h1234_5678_9ABC_DEF0;
    queue_req(0, 64'h6000, 1'b0, 64'd0);
    drain();
    fix_en = 0;

    // reset in the middle of a data transfer, late bus response afterwards
    lat_fix = 1;
    queue_req(1, 64'h7800, 1'b0, 64'd0);
    drain();
    silent = 1;
    queue_req(1, 64'h7000, 1'b0, 64'd0);
    run(6);
    do_reset(1'b1);
    silent = 0;
    run(4);
    lat_fix = 2;
    queue_req(0, 64'h8000, 1'b0, 64'd0);
    drain();

    // randomized traffic from both sides with random latency and stray bus pulses
    lat_fix = 0; p_req = 40; p_junk = 10;
    run(2500);
    p_req = 0; p_junk = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
